// File: rtl/vec_mag_arbiter_if.sv
// Stream bundle joining the requester streams, the magnitude core and the tagged
// result consumer to vec_mag_arbiter. slave = arbiter side, master = environment side.
interface vec_mag_arbiter_if #(
  parameter int COORD_WIDTH = 8,
  parameter int NUM_SRC     = 4
);
  localparam int W  = 4 * COORD_WIDTH;
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC*W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]   s_axis_tvalid;
  logic [NUM_SRC-1:0]   s_axis_tlast;
  logic [NUM_SRC-1:0]   s_axis_tready;

  logic [W-1:0]         core_tdata;
  logic                 core_tvalid;
  logic                 core_tlast;
  logic                 core_tready;

  logic [W-1:0]         res_tdata;
  logic                 res_tvalid;
  logic                 res_tlast;
  logic                 res_tready;

  logic [W-1:0]         m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic [IW-1:0]        m_axis_tid;
  logic                 m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output core_tdata, core_tvalid, core_tlast,
    input  core_tready,
    input  res_tdata, res_tvalid, res_tlast,
    output res_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  core_tdata, core_tvalid, core_tlast,
    output core_tready,
    output res_tdata, res_tvalid, res_tlast,
    input  res_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    output m_axis_tready
  );
endinterface

// File: rtl/vec_mag_arbiter.sv
// Packet-level round-robin arbiter feeding a shared magnitude core; results are tagged
// with their source from an in-order ID FIFO. Define VEC_MAG_ARB_STATS_EN for grant counters.
module vec_mag_arbiter #(
  parameter int COORD_WIDTH   = 8,
  parameter int NUM_SRC       = 4,
  parameter int ID_FIFO_DEPTH = 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  vec_mag_arbiter_if.slave               bus,
  output logic                           arb_busy_o,
  output logic [$clog2(ID_FIFO_DEPTH):0] arb_inflight_o,
  output logic                           arb_orphan_o
`ifdef VEC_MAG_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]          arb_grant_cnt_o
`endif
);
  localparam int W  = 4 * COORD_WIDTH;
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(ID_FIFO_DEPTH) + 1;
  localparam int PW = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(ID_FIFO_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] last_grant_q;

  logic [IW-1:0] rr_pick;
  logic [IW-1:0] cand;
  logic          rr_found;

  logic [IW-1:0] tag_mem [ID_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          orphan_q, orphan_d;

  logic grant_act;
  logic fifo_full;
  logic fifo_empty;
  logic g_tvalid;
  logic g_tlast;
  logic push;
  logic res_hs;
  logic pop;

  // Round-robin search starting one past the last winner
  always_comb begin
    rr_pick  = last_grant_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IW'((int'(last_grant_q) + k) % NUM_SRC);
      if (!rr_found && bus.s_axis_tvalid[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  assign grant_act  = (state_q == LOCKED);
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign g_tvalid   = bus.s_axis_tvalid[grant_q];
  assign g_tlast    = bus.s_axis_tlast[grant_q];

  assign bus.core_tdata  = bus.s_axis_tdata[grant_q*W +: W];
  assign bus.core_tlast  = g_tlast;
  assign bus.core_tvalid = grant_act && g_tvalid && !fifo_full;

  always_comb begin
    bus.s_axis_tready = '0;
    if (grant_act && !fifo_full) begin
      bus.s_axis_tready[grant_q] = bus.core_tready;
    end
  end

  // A core handshake is also the granted source's handshake, so it drives both push and release
  assign push = bus.core_tvalid && bus.core_tready;

  assign bus.m_axis_tdata  = bus.res_tdata;
  assign bus.m_axis_tlast  = bus.res_tlast;
  assign bus.m_axis_tvalid = bus.res_tvalid;
  assign bus.res_tready    = bus.m_axis_tready;
  assign bus.m_axis_tid    = fifo_empty ? '0 : tag_mem[rd_ptr_q];

  assign res_hs = bus.res_tvalid && bus.m_axis_tready;
  assign pop    = res_hs && !fifo_empty;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NUM_SRC - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (rr_found) begin
            grant_q      <= rr_pick;
            last_grant_q <= rr_pick;
            state_q      <= LOCKED;
          end
        end
        LOCKED: begin
          if (push && g_tlast) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    orphan_d = orphan_q || (res_hs && fifo_empty);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      orphan_q <= orphan_d;
    end
  end

  // Tag storage carries no reset; occupancy is tracked entirely by the pointers and count
  always_ff @(posedge aclk) begin
    if (push) begin
      tag_mem[wr_ptr_q] <= grant_q;
    end
  end

  assign arb_busy_o     = grant_act || !fifo_empty;
  assign arb_inflight_o = count_q;
  assign arb_orphan_o   = orphan_q;

`ifdef VEC_MAG_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_SRC];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else if (push) begin
      grant_cnt_q[grant_q] <= grant_cnt_q[grant_q] + 32'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt_out
    assign arb_grant_cnt_o[gi*32 +: 32] = grant_cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_vec_mag_arbiter.sv
// Bench for vec_mag_arbiter: packet-driven source models, a loopback core and a tag
// scoreboard, plus a table of result-path vectors.
`timescale 1ns/1ps
module tb_vec_mag_arbiter;
  localparam int CWD   = 8;
  localparam int NS    = 4;
  localparam int DEPTH = 8;
  localparam int W     = 4 * CWD;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          arb_busy;
  logic [CW-1:0] arb_inflight;
  logic          arb_orphan;
`ifdef VEC_MAG_ARB_STATS_EN
  logic [NS*32-1:0] arb_grant_cnt;
`endif

  vec_mag_arbiter_if #(.COORD_WIDTH(CWD), .NUM_SRC(NS)) bus ();

  vec_mag_arbiter #(
    .COORD_WIDTH  (CWD),
    .NUM_SRC      (NS),
    .ID_FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .bus           (bus),
    .arb_busy_o    (arb_busy),
    .arb_inflight_o(arb_inflight),
    .arb_orphan_o  (arb_orphan)
`ifdef VEC_MAG_ARB_STATS_EN
    ,
    .arb_grant_cnt_o(arb_grant_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  int n_issued = 0;

  int left [NS];
  int plen [NS];
  int beat [NS];
  bit [NS-1:0] hs;

  int            exp_src_q [$];
  int            exp_tag_q [$];
  logic [W-1:0]  core_q [$];
  bit            auto_core = 1'b0;
  bit            orphan_ok = 1'b0;

  typedef struct {
    logic         rv;
    logic         rl;
    logic [W-1:0] rd;
    logic         mr;
    logic         ev;
    logic         el;
    logic [W-1:0] ed;
    logic         er;
  } pv_t;
  pv_t pvec [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int info);
    n_checks++;
    n_errors++;
    $display("FAIL %s: info %0d", name, info);
  endtask

  task automatic drive_srcs();
    for (int s = 0; s < NS; s++) begin
      bus.s_axis_tvalid[s]       = (left[s] > 0);
      bus.s_axis_tlast[s]        = (plen[s] > 0) && ((beat[s] % plen[s]) == plen[s] - 1);
      bus.s_axis_tdata[s*W +: W] = {8'(s), 8'hA0, 8'(beat[s]), 8'h5A};
    end
  endtask

  // Called just before an active edge: everything seen here is what the edge will capture.
  task automatic mon_sample();
    int e;
    hs = bus.s_axis_tvalid & bus.s_axis_tready;
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_tag_q.size() > 0) begin
        chk("result_tid", 64'(bus.m_axis_tid), 64'(exp_tag_q.pop_front()));
        if (core_q.size() > 0) void'(core_q.pop_front());
      end else if (orphan_ok) begin
        chk("orphan_tid", 64'(bus.m_axis_tid), 64'd0);
      end else begin
        fail_now("unexpected_result_tid", int'(bus.m_axis_tid));
      end
    end
    if (bus.core_tvalid && bus.core_tready) begin
      n_issued++;
      if (exp_src_q.size() > 0) begin
        e = exp_src_q.pop_front();
        chk("issue_src_beat", 64'({bus.core_tdata[31:24], bus.core_tdata[15:8]}), 64'(e));
        chk("issue_ready_onehot", 64'(bus.s_axis_tready), 64'(4'b0001 << (e / 256)));
        exp_tag_q.push_back(e / 256);
      end else begin
        fail_now("unexpected_issue_src", int'(bus.core_tdata[31:24]));
      end
      if (auto_core) core_q.push_back(bus.core_tdata);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    mon_sample();
    @(posedge aclk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (hs[s]) begin
        beat[s]++;
        left[s]--;
      end
    end
    drive_srcs();
    if (auto_core) begin
      bus.res_tvalid = (core_q.size() > 0);
      bus.res_tdata  = (core_q.size() > 0) ? core_q[0] : '0;
      bus.res_tlast  = 1'b1;
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    exp_src_q.delete();
    exp_tag_q.delete();
    core_q.delete();
    for (int s = 0; s < NS; s++) begin
      left[s] = 0;
      beat[s] = 0;
      plen[s] = 1;
    end
    hs = '0;
    n_issued = 0;
    drive_srcs();
    bus.core_tready   = 1'b1;
    bus.m_axis_tready = 1'b1;
    bus.res_tvalid    = 1'b1;
    bus.res_tlast     = 1'b0;
    bus.res_tdata     = 32'hCAFE_F00D;
    #1;
    chk("rst_inflight", 64'(arb_inflight), 64'd0);
    chk("rst_busy", 64'(arb_busy), 64'd0);
    chk("rst_orphan", 64'(arb_orphan), 64'd0);
    chk("rst_src_ready", 64'(bus.s_axis_tready), 64'd0);
    chk("rst_core_tvalid", 64'(bus.core_tvalid), 64'd0);
    chk("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    chk("rst_m_tdata", 64'(bus.m_axis_tdata), 64'hCAFE_F00D);
    chk("rst_m_tid", 64'(bus.m_axis_tid), 64'd0);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    bus.res_tvalid = 1'b0;
    bus.res_tdata  = '0;
    aresetn = 1'b1;
  endtask

  function automatic bit pending();
    bit p = (exp_src_q.size() > 0) || (exp_tag_q.size() > 0);
    for (int s = 0; s < NS; s++) if (left[s] > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name, input int max_cyc);
    int c = 0;
    while (c < max_cyc && pending()) begin
      tick();
      c++;
    end
    if (pending()) begin
      fail_now({name, "_timeout"}, c);
    end else begin
      chk({name, "_end_inflight"}, 64'(arb_inflight), 64'd0);
      chk({name, "_end_busy"}, 64'(arb_busy), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b1;
    for (int s = 0; s < NS; s++) begin
      left[s] = 0;
      beat[s] = 0;
      plen[s] = 1;
    end
    drive_srcs();
    bus.core_tready   = 1'b0;
    bus.m_axis_tready = 1'b0;
    bus.res_tvalid    = 1'b0;
    bus.res_tlast     = 1'b0;
    bus.res_tdata     = '0;
    #3;
    do_reset();

    // Result path is a pure pass-through; no vector here completes a handshake.
    pvec[0] = '{rv:1'b1, rl:1'b1, rd:32'h1234_5678, mr:1'b0, ev:1'b1, el:1'b1, ed:32'h1234_5678, er:1'b0};
    pvec[1] = '{rv:1'b0, rl:1'b0, rd:32'hDEAD_BEEF, mr:1'b1, ev:1'b0, el:1'b0, ed:32'hDEAD_BEEF, er:1'b1};
    pvec[2] = '{rv:1'b1, rl:1'b0, rd:32'hFFFF_FFFF, mr:1'b0, ev:1'b1, el:1'b0, ed:32'hFFFF_FFFF, er:1'b0};
    pvec[3] = '{rv:1'b0, rl:1'b1, rd:32'h0000_0000, mr:1'b1, ev:1'b0, el:1'b1, ed:32'h0000_0000, er:1'b1};
    for (int i = 0; i < 4; i++) begin
      bus.res_tvalid    = pvec[i].rv;
      bus.res_tlast     = pvec[i].rl;
      bus.res_tdata     = pvec[i].rd;
      bus.m_axis_tready = pvec[i].mr;
      #2;
      chk("pv_m_tvalid", 64'(bus.m_axis_tvalid), 64'(pvec[i].ev));
      chk("pv_m_tlast", 64'(bus.m_axis_tlast), 64'(pvec[i].el));
      chk("pv_m_tdata", 64'(bus.m_axis_tdata), 64'(pvec[i].ed));
      chk("pv_res_tready", 64'(bus.res_tready), 64'(pvec[i].er));
      chk("pv_m_tid", 64'(bus.m_axis_tid), 64'd0);
    end
    bus.res_tvalid    = 1'b0;
    bus.m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    chk("pv_orphan_clear", 64'(arb_orphan), 64'd0);

    // Sources 0 and 2 continuously valid with single-beat packets: grants alternate.
    do_reset();
    auto_core = 1'b1;
    plen[0] = 1; left[0] = 3;
    plen[2] = 1; left[2] = 3;
    for (int k = 0; k < 3; k++) begin
      exp_src_q.push_back(0 * 256 + k);
      exp_src_q.push_back(2 * 256 + k);
    end
    drive_srcs();
    drain("rr_0_2", 60);
`ifdef VEC_MAG_ARB_STATS_EN
    chk("grant_cnt_src0", 64'(arb_grant_cnt[31:0]), 64'd3);
    chk("grant_cnt_src2", 64'(arb_grant_cnt[95:64]), 64'd3);
`endif

    // Three-beat packet on source 1 is not interrupted by source 3.
    do_reset();
    plen[1] = 3; left[1] = 3;
    plen[3] = 1; left[3] = 1;
    exp_src_q.push_back(1 * 256 + 0);
    exp_src_q.push_back(1 * 256 + 1);
    exp_src_q.push_back(1 * 256 + 2);
    exp_src_q.push_back(3 * 256 + 0);
    drive_srcs();
    drain("pkt_lock", 60);

    // Downstream stalled: the tag FIFO fills at exactly DEPTH beats.
    do_reset();
    bus.m_axis_tready = 1'b0;
    plen[0] = 10; left[0] = 10;
    for (int k = 0; k < 10; k++) exp_src_q.push_back(k);
    drive_srcs();
    for (int c = 0; c < 20; c++) tick();
    chk("full_issued", 64'(n_issued), 64'd8);
    chk("full_inflight", 64'(arb_inflight), 64'd8);
    chk("full_core_tvalid", 64'(bus.core_tvalid), 64'd0);
    chk("full_src_ready", 64'(bus.s_axis_tready), 64'd0);
    chk("full_busy", 64'(arb_busy), 64'd1);
    // One pop while full: no push that cycle, then a push the next.
    bus.m_axis_tready = 1'b1;
    tick();
    chk("pop_full_inflight", 64'(arb_inflight), 64'd7);
    chk("pop_full_core_tvalid", 64'(bus.core_tvalid), 64'd1);
    bus.m_axis_tready = 1'b0;
    tick();
    chk("refill_inflight", 64'(arb_inflight), 64'd8);
    chk("refill_core_tvalid", 64'(bus.core_tvalid), 64'd0);
    bus.m_axis_tready = 1'b1;
    drain("full_drain", 80);

    // Result with nothing issued raises a sticky orphan flag.
    do_reset();
    auto_core = 1'b0;
    orphan_ok = 1'b1;
    bus.res_tvalid = 1'b1;
    bus.res_tdata  = 32'h0BAD_0BAD;
    #1;
    chk("orphan_before", 64'(arb_orphan), 64'd0);
    tick();
    chk("orphan_set", 64'(arb_orphan), 64'd1);
    bus.res_tvalid = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("orphan_sticky", 64'(arb_orphan), 64'd1);
    chk("orphan_inflight", 64'(arb_inflight), 64'd0);
    orphan_ok = 1'b0;

    // Reset mid-packet with three tags outstanding.
    do_reset();
    auto_core = 1'b1;
    bus.m_axis_tready = 1'b0;
    plen[2] = 5; left[2] = 5;
    for (int k = 0; k < 5; k++) exp_src_q.push_back(2 * 256 + k);
    drive_srcs();
    for (int c = 0; c < 20 && n_issued < 3; c++) tick();
    chk("midpkt_issued", 64'(n_issued), 64'd3);
    chk("midpkt_inflight", 64'(arb_inflight), 64'd3);
    #2;
    do_reset();
    plen[1] = 1; left[1] = 1;
    plen[3] = 1; left[3] = 1;
    exp_src_q.push_back(1 * 256 + 0);
    exp_src_q.push_back(3 * 256 + 0);
    drive_srcs();
    drain("after_reset", 60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
